// File: rtl/seq_booth_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and helpers for the Booth multiplier.
// Revision    : 1.0
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  // Returns a 33-bit extension; callers truncate to WIDTH+1 bits.
  function automatic logic [32:0] ext_operand(input logic [31:0] value,
                                              input logic        is_signed,
                                              input int          width);
    logic [32:0] res;
    logic        fill;
    fill = is_signed & value[5'(width - 1)];
    for (int i = 0; i < 33; i++) begin
      res[i] = (i < width) ? value[i] : fill;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_booth_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_if
// Description : Start/done handshake and operand/result bus of the multiplier.
// Revision    : 1.0
// ============================================================================
interface mult_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   is_signed;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic [2*WIDTH-1:0]     M;
  logic                   busy;
  logic                   done;
  logic                   ready;

  modport master (
    output start, is_signed, A, B,
    input  M, busy, done, ready
  );

  modport slave (
    input  start, is_signed, A, B,
    output M, busy, done, ready
  );
endinterface
`default_nettype wire

// File: rtl/seq_booth_multiplier_booth_r2_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_r2_step
// Description : One combinational radix-2 Booth add/sub plus arithmetic shift.
// Revision    : 1.0
// ============================================================================
module booth_r2_step #(
  parameter int WIDTH = 8
) (
  input  wire logic [2*WIDTH+3:0] i_acc,
  input  wire logic [WIDTH:0]     i_a_ext,
  output logic      [2*WIDTH+3:0] o_acc
);
  localparam int HI_W = WIDTH + 2;
  localparam int LO_W = WIDTH + 1;

  logic [HI_W-1:0] w_hi;
  logic [LO_W-1:0] w_lo;
  logic            w_q1;
  logic [HI_W-1:0] w_a_wide;
  logic [HI_W-1:0] w_hi_sum;

  assign {w_hi, w_lo, w_q1} = i_acc;
  assign w_a_wide           = {i_a_ext[WIDTH], i_a_ext};

  always_comb begin
    w_hi_sum = w_hi;
    unique case ({w_lo[0], w_q1})
      2'b01:   w_hi_sum = w_hi + w_a_wide;
      2'b10:   w_hi_sum = w_hi - w_a_wide;
      default: w_hi_sum = w_hi;
    endcase
  end

  // Arithmetic shift of {hi,lo,q-1}: old lo[0] becomes the new q-1.
  assign o_acc = {w_hi_sum[HI_W-1], w_hi_sum, w_lo};
endmodule
`default_nettype wire

// File: rtl/seq_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_booth_multiplier
// Description : Sequential radix-2 Booth multiplier, signed/unsigned, start/done.
// Revision    : 1.0
// ============================================================================
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input wire logic clk,
  input wire logic rst_n,
  mult_if.slave    bus
);
  localparam int ACC_W = 2 * WIDTH + 4;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH:0]     r_a_ext;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_step;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_m;
  logic [WIDTH:0]     w_a_ext_in;
  logic [WIDTH:0]     w_b_ext_in;
  logic               w_accept;
  logic               w_last;

  assign w_a_ext_in = (WIDTH + 1)'(ext_operand(32'(bus.A), bus.is_signed, WIDTH));
  assign w_b_ext_in = (WIDTH + 1)'(ext_operand(32'(bus.B), bus.is_signed, WIDTH));
  assign w_accept   = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = (r_count == CNT_W'(WIDTH));

  booth_r2_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc   (r_acc),
    .i_a_ext (r_a_ext),
    .o_acc   (w_acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = bus.start ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Product sits in the low 2*WIDTH bits of {hi,lo}, just above q-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_ext <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_m     <= '0;
    end else if (w_accept) begin
      r_a_ext <= w_a_ext_in;
      r_acc   <= {(WIDTH + 2)'(0), w_b_ext_in, 1'b0};
      r_count <= '0;
    end else if (r_state == CALC) begin
      r_acc   <= w_acc_step;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_m <= w_acc_step[2*WIDTH:1];
      end
    end
  end

  assign bus.M     = r_m;
  assign bus.busy  = (r_state == CALC);
  assign bus.done  = (r_state == DONE);
  assign bus.ready = (r_state == IDLE) || (r_state == DONE);
endmodule
`default_nettype wire

// File: tb/tb_seq_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_booth_multiplier
// Description : Directed and random checks of the Booth multiplier, WIDTH 8 and 16.
// Revision    : 1.0
// ============================================================================
module tb_seq_booth_multiplier;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  mult_if #(.WIDTH(8))  b8 ();
  mult_if #(.WIDTH(16)) b16 ();

  seq_booth_multiplier #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  seq_booth_multiplier #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One WIDTH=8 op; inputs scrambled after acceptance, optional stray start during CALC.
  task automatic run8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                      input int inject_at, output int lat, output int nbusy, output int ndone);
    @(negedge clk);
    b8.start = 1'b1; b8.is_signed = sg; b8.A = a; b8.B = b;
    @(posedge clk); #1;
    b8.start = 1'b0; b8.is_signed = ~sg; b8.A = 8'($urandom); b8.B = 8'($urandom);
    lat = -1; nbusy = 0; ndone = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == inject_at) begin
        b8.start = 1'b1; b8.A = 8'd3; b8.B = 8'd5;
      end else begin
        b8.start = 1'b0;
      end
      if (b8.busy) nbusy++;
      if (b8.done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      @(posedge clk); #1;
    end
    b8.start = 1'b0;
  endtask

  task automatic run16(input logic sg, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] m, output int lat);
    @(negedge clk);
    b16.start = 1'b1; b16.is_signed = sg; b16.A = a; b16.B = b;
    @(posedge clk); #1;
    b16.start = 1'b0; b16.A = 16'($urandom); b16.B = 16'($urandom);
    lat = 0;
    while (!b16.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    m = b16.M;
  endtask

  initial begin
    int          lat, nbusy, ndone;
    logic [31:0] m16, exp16;
    logic [31:0] sa, sb;
    logic [15:0] ra, rb;
    logic        rs;

    b8.start = 1'b0;  b8.is_signed = 1'b0;  b8.A = '0;  b8.B = '0;
    b16.start = 1'b0; b16.is_signed = 1'b0; b16.A = '0; b16.B = '0;

    #3;
    check("rst_M8",     64'(b8.M),     64'd0);
    check("rst_busy8",  64'(b8.busy),  64'd0);
    check("rst_done8",  64'(b8.done),  64'd0);
    check("rst_ready8", 64'(b8.ready), 64'd1);
    check("rst_M16",    64'(b16.M),    64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Signed most-negative squared.
    run8(1'b1, 8'h80, 8'h80, -1, lat, nbusy, ndone);
    check("mn_M",     64'(b8.M), 64'h4000);
    check("mn_lat",   64'(lat),   64'd9);
    check("mn_busy",  64'(nbusy), 64'd9);
    check("mn_ndone", 64'(ndone), 64'd1);

    run8(1'b0, 8'hFF, 8'hFF, -1, lat, nbusy, ndone);
    check("uFF_M", 64'(b8.M), 64'hFE01);
    run8(1'b1, 8'hFF, 8'hFF, -1, lat, nbusy, ndone);
    check("sFF_M", 64'(b8.M), 64'h0001);

    // 55 x 114 with a stray start pulse mid-calculation.
    run8(1'b1, 8'h37, 8'h72, 3, lat, nbusy, ndone);
    check("ign_M",     64'(b8.M),     64'h187E);
    check("ign_ndone", 64'(ndone),    64'd1);
    check("ign_lat",   64'(lat),      64'd9);
    check("ign_ready", 64'(b8.ready), 64'd1);

    // Asynchronous reset 4 cycles into -55 x 114.
    @(negedge clk);
    b8.start = 1'b1; b8.is_signed = 1'b1; b8.A = 8'hC9; b8.B = 8'h72;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("arst_M",     64'(b8.M),     64'd0);
    check("arst_busy",  64'(b8.busy),  64'd0);
    check("arst_ready", 64'(b8.ready), 64'd1);
    check("arst_done",  64'(b8.done),  64'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (b8.done) ndone++;
    end
    check("arst_nodone", 64'(ndone), 64'd0);
    run8(1'b1, 8'h7F, 8'h7F, -1, lat, nbusy, ndone);
    check("p127_M", 64'(b8.M), 64'h3F01);

    // Back-to-back: start held in DONE.
    @(negedge clk);
    b8.start = 1'b1; b8.is_signed = 1'b1; b8.A = 8'hC9; b8.B = 8'h72;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("b2b_done1", 64'(b8.done), 64'd1);
    check("b2b_M1",    64'(b8.M),    64'hE782);
    b8.start = 1'b1; b8.A = 8'h00; b8.B = 8'h7F;
    @(posedge clk); #1;
    b8.start = 1'b0; b8.A = 8'h11; b8.B = 8'h22;
    check("b2b_busy",  64'(b8.busy), 64'd1);
    check("b2b_Mhold", 64'(b8.M),    64'hE782);
    repeat (9) @(posedge clk);
    #1;
    check("b2b_done2", 64'(b8.done), 64'd1);
    check("b2b_M2",    64'(b8.M),    64'h0000);
    @(posedge clk); #1;
    check("b2b_idle",  64'(b8.ready), 64'd1);

    // WIDTH=16 directed.
    run16(1'b1, 16'h8000, 16'h7FFF, m16, lat);
    check("w16_s_M",   64'(m16), 64'hC0008000);
    check("w16_s_lat", 64'(lat), 64'd17);
    run16(1'b0, 16'hFFFF, 16'h0002, m16, lat);
    check("w16_u_M",   64'(m16), 64'h0001FFFE);

    // WIDTH=16 random sweep against a sign/zero-extended 32-bit reference.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      sa = rs ? {{16{ra[15]}}, ra} : {16'h0000, ra};
      sb = rs ? {{16{rb[15]}}, rb} : {16'h0000, rb};
      exp16 = sa * sb;
      run16(rs, ra, rb, m16, lat);
      check($sformatf("sweep%0d_%s_%h_%h", n, rs ? "s" : "u", ra, rb), 64'(m16), 64'(exp16));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
